// File: rtl/macro_frame_capture.sv
// macro_frame_capture
//   Captures the per-cell macroscopic outputs of the LBM collider into a
//   ping-pong frame buffer. The host reads any cell of the last published
//   frame through the GPIO pixel-select interface while the solver keeps
//   writing the other bank.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   sample_valid        strobe: u_x/u_y/rho/u_squared belong to the next cell
//   u_x,u_y,rho,
//   u_squared           signed macroscopic values of the current cell
//   sync_clr            abort the partially written frame
//   GPIOi               [15] host read lock, [14:0] requested cell index
//   GPIOux,GPIOuy,
//   GPIOrho,GPIOu2      registered values of the selected cell
//   frame_ready         new frame published and not yet locked by the host
//   overrun             sticky: a completed frame was dropped under lock
//   frame_count         frames published, modulo 2^16
module macro_frame_capture #(
   parameter int DEPTH      = 2500,
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 12
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         sample_valid,
   input  logic signed [DATA_WIDTH-1:0] u_x,
   input  logic signed [DATA_WIDTH-1:0] u_y,
   input  logic signed [DATA_WIDTH-1:0] rho,
   input  logic signed [DATA_WIDTH-1:0] u_squared,
   input  logic                         sync_clr,
   input  logic [15:0]                  GPIOi,
   output logic signed [DATA_WIDTH-1:0] GPIOux,
   output logic signed [DATA_WIDTH-1:0] GPIOuy,
   output logic signed [DATA_WIDTH-1:0] GPIOrho,
   output logic signed [DATA_WIDTH-1:0] GPIOu2,
   output logic                         frame_ready,
   output logic                         overrun,
   output logic [15:0]                  frame_count
);

   localparam int                  WORD_W = 4 * DATA_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);

   typedef enum logic {S_IDLE, S_FILL} state_t;

   // ---------------------------------------------------------------
   // Write side
   // ---------------------------------------------------------------
   state_t                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
   logic                    wr_bank_q, wr_bank_d;
   logic [15:0]             frame_count_q, frame_count_d;
   logic                    frame_ready_q, frame_ready_d;
   logic                    overrun_q, overrun_d;
   logic                    host_q;

   logic                    host;
   logic                    wr_en;
   logic                    complete;
   logic                    publish;
   logic [ADDR_WIDTH-1:0]   wr_waddr;
   logic [WORD_W-1:0]       wr_word;

   assign host    = GPIOi[15];
   assign wr_word = {u_x, u_y, rho, u_squared};

   // A frame always starts at word 0; IDLE pins the write address there.
   assign wr_waddr = (state_q == S_IDLE) ? '0 : wr_addr_q;

   always_comb begin
      state_d   = state_q;
      wr_addr_d = wr_addr_q;
      wr_en     = 1'b0;
      complete  = 1'b0;
      if (sync_clr) begin
         // Abort wins over a coincident sample, which is dropped.
         state_d   = S_IDLE;
         wr_addr_d = '0;
      end else if (sample_valid) begin
         wr_en = 1'b1;
         if (wr_waddr == LAST) begin
            complete  = 1'b1;
            wr_addr_d = '0;
            state_d   = S_IDLE;
         end else begin
            wr_addr_d = wr_waddr + ADDR_WIDTH'(1);
            state_d   = S_FILL;
         end
      end
   end

   // The swap is decided only by the lock level at the completion edge.
   assign publish = complete & ~host;

   always_comb begin
      wr_bank_d     = wr_bank_q ^ publish;
      frame_count_d = frame_count_q + {15'd0, publish};
      overrun_d     = overrun_q | (complete & host);
      frame_ready_d = frame_ready_q;
      if (host & ~host_q)
         frame_ready_d = 1'b0;
      if (publish)
         frame_ready_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= S_IDLE;
         wr_addr_q     <= '0;
         wr_bank_q     <= 1'b0;
         frame_count_q <= '0;
         frame_ready_q <= 1'b0;
         overrun_q     <= 1'b0;
         host_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         wr_addr_q     <= wr_addr_d;
         wr_bank_q     <= wr_bank_d;
         frame_count_q <= frame_count_d;
         frame_ready_q <= frame_ready_d;
         overrun_q     <= overrun_d;
         host_q        <= host;
      end
   end

   // ---------------------------------------------------------------
   // Storage: two banks, synchronous read
   // ---------------------------------------------------------------
   logic [WORD_W-1:0]     bank0 [0:DEPTH-1];
   logic [WORD_W-1:0]     bank1 [0:DEPTH-1];

   logic [14:0]           idx_q;
   logic [1:0]            vld_pipe;
   logic                  oor;
   logic                  oor_q;
   logic [ADDR_WIDTH-1:0] rd_addr;
   logic [WORD_W-1:0]     rd_word_q;

   assign oor     = (idx_q >= 15'(DEPTH));
   // Out-of-range indices are steered to word 0 so the array is never
   // addressed past its end; the result is masked to zero later.
   assign rd_addr = oor ? '0 : idx_q[ADDR_WIDTH-1:0];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         if (wr_bank_q)
            bank1[wr_waddr] <= wr_word;
         else
            bank0[wr_waddr] <= wr_word;
      end
      // Read bank is always the one not being written.
      rd_word_q <= wr_bank_q ? bank0[rd_addr] : bank1[rd_addr];
   end

   // ---------------------------------------------------------------
   // Read pipeline: index reg -> RAM read -> GPIO load
   // ---------------------------------------------------------------
   logic [DATA_WIDTH-1:0] gpio_ux_q, gpio_uy_q, gpio_rho_q, gpio_u2_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         idx_q      <= '0;
         vld_pipe   <= '0;
         oor_q      <= 1'b0;
         gpio_ux_q  <= '0;
         gpio_uy_q  <= '0;
         gpio_rho_q <= '0;
         gpio_u2_q  <= '0;
      end else begin
         if (host)
            idx_q <= GPIOi[14:0];
         vld_pipe <= {vld_pipe[0], host};
         oor_q    <= oor;
         if (vld_pipe[1]) begin
            if (oor_q) begin
               gpio_ux_q  <= '0;
               gpio_uy_q  <= '0;
               gpio_rho_q <= '0;
               gpio_u2_q  <= '0;
            end else begin
               gpio_ux_q  <= rd_word_q[4*DATA_WIDTH-1:3*DATA_WIDTH];
               gpio_uy_q  <= rd_word_q[3*DATA_WIDTH-1:2*DATA_WIDTH];
               gpio_rho_q <= rd_word_q[2*DATA_WIDTH-1:DATA_WIDTH];
               gpio_u2_q  <= rd_word_q[DATA_WIDTH-1:0];
            end
         end
      end
   end

   assign GPIOux      = gpio_ux_q;
   assign GPIOuy      = gpio_uy_q;
   assign GPIOrho     = gpio_rho_q;
   assign GPIOu2      = gpio_u2_q;
   assign frame_ready = frame_ready_q;
   assign overrun     = overrun_q;
   assign frame_count = frame_count_q;

endmodule

// File: tb/tb_macro_frame_capture.sv
// Directed bench for macro_frame_capture: frame fill/publish, read latency,
// lock-at-completion overrun, back-to-back frames, sync_clr, out-of-range
// reads and asynchronous reset mid-frame.
module tb_macro_frame_capture;

   logic        clk;
   logic        rst;
   logic        sample_valid;
   logic [15:0] u_x, u_y, rho, u_squared;
   logic        sync_clr;
   logic [15:0] GPIOi;
   logic [15:0] GPIOux, GPIOuy, GPIOrho, GPIOu2;
   logic        frame_ready;
   logic        overrun;
   logic [15:0] frame_count;

   int ncmp;
   int nfail;

   macro_frame_capture #(.DEPTH(2500), .DATA_WIDTH(16), .ADDR_WIDTH(12)) dut (
      .clk          (clk),
      .rst          (rst),
      .sample_valid (sample_valid),
      .u_x          (u_x),
      .u_y          (u_y),
      .rho          (rho),
      .u_squared    (u_squared),
      .sync_clr     (sync_clr),
      .GPIOi        (GPIOi),
      .GPIOux       (GPIOux),
      .GPIOuy       (GPIOuy),
      .GPIOrho      (GPIOrho),
      .GPIOu2       (GPIOu2),
      .frame_ready  (frame_ready),
      .overrun      (overrun),
      .frame_count  (frame_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Cell c carries u_x=base+c, u_y=c, rho=rhov, u_squared=base^c.
   task automatic drive_cells(input int first, input int n,
                              input logic [15:0] base, input logic [15:0] rhov);
      for (int i = 0; i < n; i++) begin
         sample_valid = 1'b1;
         u_x          = base + 16'(first + i);
         u_y          = 16'(first + i);
         rho          = rhov;
         u_squared    = base ^ 16'(first + i);
         tick();
      end
   endtask

   // Apply a locked index and wait for the GPIO outputs (three edges).
   task automatic rd(input int idx);
      GPIOi = 16'h8000 | 16'(idx);
      tick();
      tick();
      tick();
   endtask

   initial begin
      ncmp         = 0;
      nfail        = 0;
      rst          = 1'b1;
      sample_valid = 1'b0;
      u_x = '0; u_y = '0; rho = '0; u_squared = '0;
      sync_clr     = 1'b0;
      GPIOi        = '0;

      // ---- reset then idle
      #2 rst = 1'b0;
      tick(); tick();
      chk("rst_ux",    GPIOux, 0);
      chk("rst_uy",    GPIOuy, 0);
      chk("rst_rho",   GPIOrho, 0);
      chk("rst_u2",    GPIOu2, 0);
      chk("rst_ready", frame_ready, 0);
      chk("rst_ovr",   overrun, 0);
      chk("rst_cnt",   frame_count, 0);
      rst = 1'b1;
      tick(); tick(); tick(); tick();
      chk("idle_ux",   GPIOux, 0);
      chk("idle_rho",  GPIOrho, 0);

      // ---- single frame, u_x = index, rho = 0x1000
      drive_cells(0, 2500, 16'h0000, 16'h1000);
      sample_valid = 1'b0;
      chk("f1_ready", frame_ready, 1);
      chk("f1_cnt",   frame_count, 1);
      GPIOi = 16'h8000 | 16'd1234;
      tick();
      chk("f1_ready_clr", frame_ready, 0);
      tick();
      chk("f1_lat2_ux", GPIOux, 0);
      tick();
      chk("f1_ux",  GPIOux, 1234);
      chk("f1_uy",  GPIOuy, 1234);
      chk("f1_rho", GPIOrho, 16'h1000);
      chk("f1_u2",  GPIOu2, 1234);
      // one index per cycle
      GPIOi = 16'h8000;
      tick();
      GPIOi = 16'h8000 | 16'd2499;
      tick();
      tick();
      chk("tp_ux0", GPIOux, 0);
      tick();
      chk("tp_ux2499", GPIOux, 2499);

      // ---- lock held through completion of frame 2
      GPIOi = 16'h8000 | 16'd7;
      drive_cells(0, 2500, 16'h5000, 16'h2000);
      sample_valid = 1'b0;
      tick();
      chk("lk_ovr",   overrun, 1);
      chk("lk_cnt",   frame_count, 1);
      chk("lk_ready", frame_ready, 0);
      chk("lk_ux",    GPIOux, 7);
      chk("lk_rho",   GPIOrho, 16'h1000);

      // ---- back-to-back frames 3 and 4, no gap
      GPIOi = '0;
      drive_cells(0, 2500, 16'h1000, 16'h3000);
      chk("bb_cnt_mid", frame_count, 2);
      drive_cells(0, 2500, 16'h2000, 16'h4000);
      sample_valid = 1'b0;
      chk("bb_cnt",   frame_count, 3);
      chk("bb_ready", frame_ready, 1);
      chk("bb_ovr",   overrun, 1);
      rd(0);
      chk("bb_ux0",  GPIOux, 16'h2000);
      chk("bb_rho0", GPIOrho, 16'h4000);
      chk("bb_ready_clr", frame_ready, 0);
      rd(2499);
      chk("bb_ux2499", GPIOux, 16'h29C3);
      chk("bb_u22499", GPIOu2, 16'h29C3);

      // ---- sync_clr at cell 1000, coincident sample dropped
      GPIOi = '0;
      drive_cells(0, 1000, 16'h7000, 16'h7000);
      sync_clr     = 1'b1;
      sample_valid = 1'b1;
      u_x          = 16'h7777;
      tick();
      sync_clr = 1'b0;
      drive_cells(0, 2499, 16'h3000, 16'h5000);
      chk("sc_cnt_early",   frame_count, 3);
      chk("sc_ready_early", frame_ready, 0);
      drive_cells(2499, 1, 16'h3000, 16'h5000);
      sample_valid = 1'b0;
      chk("sc_cnt",   frame_count, 4);
      chk("sc_ready", frame_ready, 1);
      rd(0);
      chk("sc_ux0",  GPIOux, 16'h3000);
      chk("sc_uy0",  GPIOuy, 0);
      chk("sc_rho0", GPIOrho, 16'h5000);
      rd(999);
      chk("sc_ux999", GPIOux, 16'h33E7);
      rd(2499);
      chk("sc_ux2499", GPIOux, 16'h39C3);

      // ---- out-of-range indices
      rd(2500);
      chk("oor2500_ux", GPIOux, 0);
      rd(1);
      chk("oor_pre_ux", GPIOux, 16'h3001);
      rd(2600);
      chk("oor_ux",  GPIOux, 0);
      chk("oor_uy",  GPIOuy, 0);
      chk("oor_rho", GPIOrho, 0);
      chk("oor_u2",  GPIOu2, 0);

      // ---- asynchronous reset mid-frame
      rd(1);
      GPIOi = '0;
      drive_cells(0, 500, 16'h6000, 16'h6000);
      sample_valid = 1'b0;
      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      chk("ar_ux",    GPIOux, 0);
      chk("ar_rho",   GPIOrho, 0);
      chk("ar_ready", frame_ready, 0);
      chk("ar_ovr",   overrun, 0);
      chk("ar_cnt",   frame_count, 0);
      #3 rst = 1'b1;
      tick();
      drive_cells(0, 2499, 16'h0A00, 16'h0B00);
      chk("ar_cnt_early", frame_count, 0);
      drive_cells(2499, 1, 16'h0A00, 16'h0B00);
      sample_valid = 1'b0;
      chk("ar_cnt_pub", frame_count, 1);
      chk("ar_ready_pub", frame_ready, 1);
      rd(0);
      chk("ar_ux0",  GPIOux, 16'h0A00);
      chk("ar_rho0", GPIOrho, 16'h0B00);
      rd(2499);
      chk("ar_ux2499", GPIOux, 16'h13C3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule

// File: doc/macro_frame_capture.md
# macro_frame_capture

Downstream consumer of the pipelined LBM top level. It captures the per-cell macroscopic outputs (u_x, u_y, rho, u_squared) as the collider produces them and assembles them into complete frames in a ping-pong buffer. It serves any cell of the last complete frame to the host through the GPIO pixel-select interface. The host always reads a coherent frame while the solver keeps running.

## Interface
- DEPTH, 2500: cells per frame; equals `DEPTH` in def.vh.
- DATA_WIDTH, 16: width of each macroscopic quantity.
- ADDR_WIDTH, 12: cell index width; must satisfy 2^ADDR_WIDTH ≥ DEPTH.
- clk  in  1  single system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- sample_valid  in  1  one-cycle strobe: the current u_x/u_y/rho/u_squared belong to the next cell in raster order.
- u_x, u_y, rho, u_squared  in  DATA_WIDTH each  signed macroscopic values from the solver.
- sync_clr  in  1  synchronous abort of the partially written frame.
- GPIOi  in  16  [15] host_transmission (read lock); [14:0] requested cell index.
- GPIOux, GPIOuy, GPIOrho, GPIOu2  out  DATA_WIDTH each  registered, signed values of the selected cell.
- frame_ready  out  1  a new frame has been published and the host has not yet locked it.
- overrun  out  1  sticky flag: a completed frame was dropped because the host held the lock.
- frame_count  out  16  number of frames published; wraps modulo 2^16.

## Operation
- Storage: two banks. Each bank holds DEPTH words of 4×DATA_WIDTH bits. The read port is synchronous.
- Banks: wr_bank selects the bank being written; the read bank is !wr_bank.
- Write side, state machine IDLE → FILL → IDLE:
  - IDLE, wr_addr = 0: the first sample_valid writes word 0 and moves to FILL.
  - FILL: each sample_valid writes the 4-tuple at wr_addr, then wr_addr increments.
  - When the sample at wr_addr = DEPTH-1 is written, wr_addr returns to 0 and the block returns to IDLE.
- Frame completion (the edge that writes cell DEPTH-1):
  - If host_transmission = 0 at that edge: wr_bank toggles, frame_count increments, frame_ready is set.
  - If host_transmission = 1 at that edge: no toggle; the frame is discarded and overrun is set. The next frame overwrites the same bank.
- sync_clr = 1: wr_addr is set to 0, state goes to IDLE, no publish occurs. sync_clr has priority over a simultaneous sample_valid, whose sample is dropped.
- Read side:
  - While host_transmission = 1: the cell index GPIOi[14:0] is registered, the read bank is read, and the four GPIO outputs are loaded.
  - An index ≥ DEPTH loads 0 on all four outputs.
  - While host_transmission = 0: the GPIO outputs hold their last values.
- frame_ready is cleared on the cycle host_transmission rises 0→1. If a publish occurs in the same cycle as the clear, the publish (set) wins.
- overrun stays set until reset.

## Timing
- Reset (rst low, asynchronous): all outputs are 0; wr_bank = 0, wr_addr = 0, state IDLE. Reset mid-frame discards the partial frame.
- Write latency: 0. A sample is committed on the edge where sample_valid is high. The solver may assert sample_valid every cycle.
- Publish: the toggle takes effect on the same edge that writes cell DEPTH-1. A sample_valid on the very next cycle writes word 0 of the new write bank.
- Read latency:
  - An index applied before edge N is registered at N.
  - The RAM read completes at N+1.
  - GPIO outputs are valid after edge N+2.
  - Throughput is one index per cycle.
- Lock coherence: the bank swap is evaluated only against host_transmission at the completion edge. A host that asserts the lock one cycle before completion keeps the old frame and causes an overrun.
- Read and write never target the same bank, so there are no read/write collisions.

## Test plan
- Reset then idle: all outputs 0, frame_ready 0, frame_count 0. Release rst and leave GPIOi = 0 → outputs stay 0.
- Single frame: drive 2500 samples with u_x = cell index, rho = 0x1000, lock off → frame_ready = 1 and frame_count = 1. Then set GPIOi = 0x8000 | 1234 → GPIOux = 1234 and GPIOrho = 0x1000 three edges later; frame_ready clears.
- Lock during completion: keep GPIOi[15] = 1 through the end of the second frame → overrun = 1, frame_count stays 1, reads still return frame-1 data.
- Back-to-back: 5000 consecutive cycles of sample_valid → frame_count = 2, no gap. Cell 0 of frame 2 is written on the cycle immediately after cell 2499 of frame 1.
- sync_clr at cell 1000, then 2500 fresh samples → exactly one publish, containing only the fresh data. Also check sync_clr asserted together with sample_valid (sample dropped).
- Out-of-range index: GPIOi = 0x8000 | 2600 → all four GPIO outputs are 0. Asynchronous rst pulse mid-frame → all outputs are 0 immediately and wr_addr restarts at 0.
